// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_pkg
//  Description : Shared constants and types for the 10-bit word deserializer.
//                Holds the four control tokens, the word width and the
//                alignment state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    localparam int WORD_W = 10;

    // Control tokens, bit 9 leftmost; bit 0 is the first bit on the wire.
    localparam logic [WORD_W-1:0] TOK_00 = 10'b1101010100;
    localparam logic [WORD_W-1:0] TOK_01 = 10'b0010101011;
    localparam logic [WORD_W-1:0] TOK_10 = 10'b0101010100;
    localparam logic [WORD_W-1:0] TOK_11 = 10'b1010101011;

    // Last value of the bit-position counter inside a word.
    localparam logic [3:0] PHASE_LAST = 4'd9;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/deserializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : deserializer_if
//  Description : Serial input and recovered-word outputs of the deserializer.
//                master = deserializer side, slave = stream source / consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface deserializer_if;
    import video_pkg::*;

    logic              serial_in;
    logic [WORD_W-1:0] data_out;
    logic              data_valid;
    logic              is_ctrl;
    logic [1:0]        ctrl;
    logic              locked;

    modport master (
        input  serial_in,
        output data_out,
        output data_valid,
        output is_ctrl,
        output ctrl,
        output locked
    );

    modport slave (
        output serial_in,
        input  data_out,
        input  data_valid,
        input  is_ctrl,
        input  ctrl,
        input  locked
    );

endinterface
`default_nettype wire

// File: rtl/token_match.sv
`default_nettype none
// ============================================================================
//  Module      : token_match
//  Description : Purely combinational compare of a 10-bit word against the
//                four control tokens; reports a hit and the 2-bit token code.
//  Revision    : 1.0 - initial release
// ============================================================================
module token_match
    import video_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic              hit,
    output logic [1:0]        code
);

    // Decode the word into a token hit and its code (code is 0 on no hit).
    always_comb begin
        hit  = 1'b0;
        code = 2'b00;
        case (word)
            TOK_00: begin hit = 1'b1; code = 2'b00; end
            TOK_01: begin hit = 1'b1; code = 2'b01; end
            TOK_10: begin hit = 1'b1; code = 2'b10; end
            TOK_11: begin hit = 1'b1; code = 2'b11; end
            default: begin hit = 1'b0; code = 2'b00; end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : deserializer
//  Description : Bit-rate deserializer for 10-bit words (LSB first). Finds word
//                alignment from control tokens, then strobes out one aligned
//                word every 10 clocks with token decode.
//                Optional macro DESER_RELOCK_EN: while locked, MISS_MAX
//                misaligned token hits drop back to the search state.
//  Revision    : 1.0 - initial release
// ============================================================================
module deserializer
    import video_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int MISS_MAX = 3
) (
    input  wire logic        clk,
    input  wire logic        rst,
    deserializer_if.master   bus
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);

    logic [WORD_W-1:0]  sr;
    logic [3:0]         phase;
    state_t             state;
    logic [MATCH_W-1:0] match_cnt;

    logic [WORD_W-1:0]  out_word;
    logic               out_valid;
    logic               out_is_ctrl;
    logic [1:0]         out_ctrl;
    logic               lock_flag;

    logic               hit;
    logic [1:0]         code;
    logic               aligned;

`ifdef DESER_RELOCK_EN
    localparam int MISS_W = $clog2(MISS_MAX + 1);
    logic [MISS_W-1:0]  miss_cnt;
`else
    // The miss threshold only matters when relock is built in.
    if (MISS_MAX < 1) begin : g_miss_max_unused
    end
`endif

    assign aligned = (phase == 4'd0);

    token_match u_token_match (
        .word (sr),
        .hit  (hit),
        .code (code)
    );

    // Shift each new bit in at the top so sr[0] holds the oldest bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= {bus.serial_in, sr[WORD_W-1:1]};
        end
    end

    // Alignment FSM with bit-phase counter and registered word outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= 4'd0;
            state       <= SEARCH;
            match_cnt   <= '0;
            out_word    <= '0;
            out_valid   <= 1'b0;
            out_is_ctrl <= 1'b0;
            out_ctrl    <= 2'b00;
            lock_flag   <= 1'b0;
`ifdef DESER_RELOCK_EN
            miss_cnt    <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            phase     <= (phase == PHASE_LAST) ? 4'd0 : phase + 4'd1;

            case (state)
                SEARCH: begin
                    // A token anywhere defines the word boundary: this cycle
                    // becomes phase 0 so the next edge starts at phase 1.
                    if (hit) begin
                        phase     <= 4'd1;
                        match_cnt <= MATCH_W'(1);
                        state     <= CHECK;
                    end
                end

                CHECK: begin
                    if (aligned) begin
                        if (hit) begin
                            match_cnt <= match_cnt + 1'b1;
                            if (int'(match_cnt) + 1 >= LOCK_CNT) begin
                                state     <= LOCKED;
                                lock_flag <= 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                            state     <= SEARCH;
                        end
                    end
                end

                LOCKED: begin
                    if (aligned) begin
                        out_word    <= sr;
                        out_valid   <= 1'b1;
                        out_is_ctrl <= hit;
                        out_ctrl    <= hit ? code : 2'b00;
`ifdef DESER_RELOCK_EN
                        if (hit) begin
                            miss_cnt <= '0;
                        end
                    end else if (hit) begin
                        // A token off the word boundary means the stream slipped.
                        if (int'(miss_cnt) + 1 >= MISS_MAX) begin
                            miss_cnt  <= '0;
                            match_cnt <= '0;
                            lock_flag <= 1'b0;
                            state     <= SEARCH;
                        end else begin
                            miss_cnt <= miss_cnt + 1'b1;
                        end
`endif
                    end
                end

                default: begin
                    state     <= SEARCH;
                    lock_flag <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out   = out_word;
    assign bus.data_valid = out_valid;
    assign bus.is_ctrl    = out_is_ctrl;
    assign bus.ctrl       = out_ctrl;
    assign bus.locked     = lock_flag;

endmodule
`default_nettype wire

// File: tb/tb_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_deserializer
//  Description : Scoreboard bench for deserializer. Stimulus pushes the
//                expected strobe (word, token decode, edge number) into a
//                queue; a monitor pops on every data_valid and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_deserializer;

    logic clk = 1'b0;
    logic rst;
    int   edge_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;

    typedef struct {
        logic [9:0] data;
        logic       is_ctrl;
        logic [1:0] ctrl;
        int         edge_no;
    } exp_t;

    exp_t q[$];

    deserializer_if bus();

    deserializer #(
        .LOCK_CNT (4),
        .MISS_MAX (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic tok_hit(input logic [9:0] w);
        return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
    endfunction

    function automatic logic [1:0] tok_code(input logic [9:0] w);
        case (w)
            10'h354: return 2'd0;
            10'h0AB: return 2'd1;
            10'h154: return 2'd2;
            10'h2AB: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.serial_in = b;
        @(posedge clk);
        #1;
    endtask

    // Send word w LSB first. If strobe, expect data_out = ed at edge
    // (last edge before this call) + 10 + lat. chk_lock >= 0 checks locked
    // right after the edge that samples bit 0.
    task automatic send_word(input logic [9:0] w, input bit strobe, input logic [9:0] ed,
                             input int lat, input int chk_lock);
        exp_t e;
        if (strobe) begin
            e.data    = ed;
            e.is_ctrl = tok_hit(ed);
            e.ctrl    = tok_code(ed);
            e.edge_no = edge_cnt + 10 + lat;
            q.push_back(e);
        end
        for (int i = 0; i < 10; i++) begin
            send_bit(w[i]);
            if (i == 0 && chk_lock >= 0) check("locked_at_word_start", {31'd0, bus.locked}, chk_lock);
        end
    endtask

    task automatic sw(input logic [9:0] w, input bit strobe, input int chk_lock);
        send_word(w, strobe, w, 1, chk_lock);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        send_bit(1'b0);
        send_bit(1'b0);
        rst = 1'b0;
    endtask

    task automatic lock_on(input logic [9:0] t);
        sw(t, 1'b0, -1);
        sw(t, 1'b0, 0);
        sw(t, 1'b0, 0);
        sw(t, 1'b0, 0);
    endtask

    // Monitor: reset values, strobe contents and timing, hold between strobes.
    initial begin : monitor
        logic       rst_s;
        logic [9:0] last_data = '0;
        logic       last_isc  = 1'b0;
        logic [1:0] last_ctrl = 2'b00;
        exp_t       e;
        forever begin
            @(posedge clk);
            rst_s = rst;
            #1;
            if (rst_s) begin
                check("rst_outputs", {19'd0, bus.data_out, bus.data_valid, bus.is_ctrl, bus.ctrl, bus.locked}, 32'd0);
                last_data = '0;
                last_isc  = 1'b0;
                last_ctrl = 2'b00;
            end else if (bus.data_valid) begin
                check("valid_expected", {31'd0, q.size() != 0}, 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("data_out", {22'd0, bus.data_out}, {22'd0, e.data});
                    check("is_ctrl_ctrl", {29'd0, bus.is_ctrl, bus.ctrl}, {29'd0, e.is_ctrl, e.ctrl});
                    check("strobe_edge", edge_cnt, e.edge_no);
                end
                last_data = bus.data_out;
                last_isc  = bus.is_ctrl;
                last_ctrl = bus.ctrl;
            end else begin
                check("hold_between_strobes", {19'd0, bus.data_out, bus.is_ctrl, bus.ctrl},
                      {19'd0, last_data, last_isc, last_ctrl});
            end
        end
    end

    initial begin : stimulus
        bit interleave;
`ifdef DESER_RELOCK_EN
        interleave = 1'b1;
`else
        interleave = 1'b0;
`endif
        rst = 1'b1;
        bus.serial_in = 1'b0;

        // Reset held 5 cycles with random serial input.
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
        check("reset_data_out", {22'd0, bus.data_out}, 32'd0);
        check("reset_flags", {28'd0, bus.data_valid, bus.is_ctrl, bus.locked, 1'b0}, 32'd0);
        check("reset_ctrl", {30'd0, bus.ctrl}, 32'd0);
        rst = 1'b0;

        // Lock acquisition at bit offset 3, then data words.
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        lock_on(10'h354);
        sw(10'h354, 1'b1, 1);
        sw(10'h354, 1'b1, 1);
        sw(10'h155, 1'b1, 1);
        sw(10'h2AA, 1'b1, 1);
        send_bit(1'b0);
        check("locked_after_data", {31'd0, bus.locked}, 32'd1);
        do_reset();

        // Failed check: two tokens then data returns to search.
        sw(10'h154, 1'b0, -1);
        sw(10'h154, 1'b0, 0);
        sw(10'h0F0, 1'b0, 0);
        sw(10'h354, 1'b0, 0);
        sw(10'h354, 1'b0, 0);
        sw(10'h354, 1'b0, 0);
        sw(10'h354, 1'b0, 0);
        sw(10'h354, 1'b1, 1);
        send_bit(1'b0);
        do_reset();

        // Mid-operation reset at phase 5 while locked, then relock.
        lock_on(10'h354);
        sw(10'h354, 1'b1, 1);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        rst = 1'b1;
        send_bit(1'b1);
        rst = 1'b0;
        check("midrst_locked", {31'd0, bus.locked}, 32'd0);
        check("midrst_valid", {31'd0, bus.data_valid}, 32'd0);
        lock_on(10'h354);
        sw(10'h354, 1'b1, 1);
        send_bit(1'b0);
        do_reset();

        // Counting pattern after lock.
        lock_on(10'h354);
        for (int w = 0; w < 1024; w++) begin
            sw(10'(w), 1'b1, (w == 0) ? 1 : -1);
            if (interleave) sw(10'h354, 1'b1, -1);
        end
        send_bit(1'b0);
        do_reset();

        // One-bit slip after lock, followed by 01 tokens.
        lock_on(10'h0AB);
        sw(10'h0AB, 1'b1, 1);
        send_bit(1'b0);
`ifdef DESER_RELOCK_EN
        send_word(10'h0AB, 1'b1, 10'h156, 0, 1);
        send_word(10'h0AB, 1'b1, 10'h156, 0, 1);
        send_word(10'h0AB, 1'b1, 10'h156, 0, 1);
        send_word(10'h0AB, 1'b0, 10'h000, 0, 0);
        send_word(10'h0AB, 1'b0, 10'h000, 0, 0);
        send_word(10'h0AB, 1'b0, 10'h000, 0, 0);
        send_word(10'h0AB, 1'b0, 10'h000, 0, 0);
        send_word(10'h0AB, 1'b1, 10'h0AB, 1, 1);
`else
        for (int k = 0; k < 8; k++) send_word(10'h0AB, 1'b1, 10'h156, 0, 1);
`endif
        send_bit(1'b0);
        check("slip_final_locked", {31'd0, bus.locked}, 32'd1);
        do_reset();

        send_bit(1'b0);
        check("scoreboard_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
